// File: rtl/muldiv_hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_hilo_ctrl_pkg
//  Description : Shared operation codes, sequencer states and helper
//                functions for the multi-cycle multiply/divide unit.
//  Revision    : 1.0  initial release
// ============================================================================
package muldiv_hilo_ctrl_pkg;

    // Operation codes presented by the decoder (ALU codes never reach here)
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    // Sequencer states
    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_PREP = 2'd1,
        MDS_CALC = 2'd2,
        MDS_FIN  = 2'd3
    } md_state_e;

    // LO value written when dividing by zero
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    // True for the operations that run through the iterative datapath
    function automatic logic md_is_muldiv(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    // True for the divide operations
    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    // True for the operations that treat operands as two's complement
    function automatic logic md_is_signed(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage : muldiv_hilo_ctrl_pkg
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Registered unsigned magnitude datapath. One shift-add
//                multiply step or one restoring-divide step per cycle.
//                Multiply: {acc_hi,acc_lo} ends as the 2*DATA_W product.
//                Divide  : acc_hi ends as remainder, acc_lo as quotient.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_iter #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic                  is_div_i,
    input  logic [DATA_W-1:0]     a_mag_i,
    input  logic [DATA_W-1:0]     b_mag_i,
    output logic [2*DATA_W-1:0]   result_o
);

    logic [DATA_W-1:0] acc_hi_q, acc_hi_d;
    logic [DATA_W-1:0] acc_lo_q, acc_lo_d;
    logic [DATA_W-1:0] opb_q,    opb_d;

    logic [DATA_W:0]   sum_w;
    logic [DATA_W:0]   shifted_w;
    logic [DATA_W:0]   diff_w;
    logic [DATA_W:0]   add_pick_w;

    // Next-state of the accumulators for one multiply or divide iteration
    always_comb begin
        acc_hi_d   = acc_hi_q;
        acc_lo_d   = acc_lo_q;
        opb_d      = opb_q;
        sum_w      = {1'b0, acc_hi_q} + {1'b0, opb_q};
        shifted_w  = {acc_hi_q, acc_lo_q[DATA_W-1]};
        // A borrow into the top bit means the partial remainder is below the divisor
        diff_w     = shifted_w - {1'b0, opb_q};
        add_pick_w = acc_lo_q[0] ? sum_w : {1'b0, acc_hi_q};

        if (load_i) begin
            acc_hi_d = '0;
            acc_lo_d = a_mag_i;
            opb_d    = b_mag_i;
        end else if (step_i) begin
            if (is_div_i) begin
                if (!diff_w[DATA_W]) begin
                    acc_hi_d = diff_w[DATA_W-1:0];
                    acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b1};
                end else begin
                    acc_hi_d = shifted_w[DATA_W-1:0];
                    acc_lo_d = {acc_lo_q[DATA_W-2:0], 1'b0};
                end
            end else begin
                acc_hi_d = add_pick_w[DATA_W:1];
                acc_lo_d = {add_pick_w[0], acc_lo_q[DATA_W-1:1]};
            end
        end
    end

    // Accumulator and operand registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            opb_q    <= '0;
        end else begin
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
            opb_q    <= opb_d;
        end
    end

    assign result_o = {acc_hi_q, acc_lo_q};

endmodule : muldiv_iter
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_hilo_ctrl
//  Description : MULT/MULTU/DIV/DIVU sequencer and owner of the HI/LO
//                registers. Holds the pipeline for 35 cycles per operation
//                and writes HI/LO once at completion. MTHI/MTLO write in
//                a single cycle without stalling.
//  Revision    : 1.0  initial release
// ============================================================================
module muldiv_hilo_ctrl
    import muldiv_hilo_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              cancel_i,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    md_state_e         state_q,   state_d;
    md_op_e            op_q,      op_d;
    logic [DATA_W-1:0] a_q,       a_d;
    logic [DATA_W-1:0] b_q,       b_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    logic [DATA_W-1:0] hi_q,      hi_d;
    logic [DATA_W-1:0] lo_q,      lo_d;

    logic                load_w;
    logic                step_w;
    logic                op_signed_w;
    logic [DATA_W-1:0]   a_mag_w;
    logic [DATA_W-1:0]   b_mag_w;
    logic [2*DATA_W-1:0] raw_w;
    logic [2*DATA_W-1:0] prod_w;
    logic [DATA_W-1:0]   quo_w;
    logic [DATA_W-1:0]   rem_w;

    // Magnitudes fed to the datapath when it is loaded in PREP
    always_comb begin
        op_signed_w = md_is_signed(op_q);
        a_mag_w     = (op_signed_w && a_q[DATA_W-1]) ? (DATA_W'(0) - a_q) : a_q;
        b_mag_w     = (op_signed_w && b_q[DATA_W-1]) ? (DATA_W'(0) - b_q) : b_q;
    end

    assign load_w = (state_q == MDS_PREP);
    assign step_w = (state_q == MDS_CALC);

    muldiv_iter #(
        .DATA_W   (DATA_W)
    ) u_iter (
        .clk      (clk),
        .resetn   (resetn),
        .load_i   (load_w),
        .step_i   (step_w),
        .is_div_i (md_is_div(op_q)),
        .a_mag_i  (a_mag_w),
        .b_mag_i  (b_mag_w),
        .result_o (raw_w)
    );

    // Sign correction of the magnitude result
    always_comb begin
        prod_w = neg_res_q ? ((2*DATA_W)'(0) - raw_w) : raw_w;
        quo_w  = neg_res_q ? (DATA_W'(0) - raw_w[DATA_W-1:0]) : raw_w[DATA_W-1:0];
        rem_w  = neg_rem_q ? (DATA_W'(0) - raw_w[2*DATA_W-1:DATA_W])
                           : raw_w[2*DATA_W-1:DATA_W];
    end

    // Sequencer next-state, operand capture and HI/LO update
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (cancel_i && (state_q != MDS_IDLE)) begin
            // Flush: abandon the operation, HI/LO keep their values
            state_d = MDS_IDLE;
        end else begin
            case (state_q)
                MDS_IDLE: begin
                    if (start_i && !cancel_i) begin
                        if (md_is_muldiv(op_i)) begin
                            op_d    = md_op_e'(op_i);
                            a_d     = a_i;
                            b_d     = b_i;
                            state_d = MDS_PREP;
                        end else if (op_i == MD_MTHI) begin
                            hi_d = a_i;
                        end else if (op_i == MD_MTLO) begin
                            lo_d = a_i;
                        end
                    end
                end
                MDS_PREP: begin
                    neg_res_d = op_signed_w && (a_q[DATA_W-1] ^ b_q[DATA_W-1]);
                    neg_rem_d = op_signed_w && a_q[DATA_W-1];
                    cnt_d     = '0;
                    state_d   = MDS_CALC;
                end
                MDS_CALC: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = MDS_FIN;
                    end
                end
                MDS_FIN: begin
                    if (md_is_div(op_q)) begin
                        if (b_q == '0) begin
                            // Divide by zero yields all-ones quotient, dividend as remainder
                            hi_d = a_q;
                            lo_d = DATA_W'(DIV0_LO);
                        end else begin
                            hi_d = rem_w;
                            lo_d = quo_w;
                        end
                    end else begin
                        hi_d = prod_w[2*DATA_W-1:DATA_W];
                        lo_d = prod_w[DATA_W-1:0];
                    end
                    state_d = MDS_IDLE;
                end
                default: state_d = MDS_IDLE;
            endcase
        end
    end

    // Sequencer and architectural register state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= MDS_IDLE;
            op_q      <= MD_NONE;
            a_q       <= '0;
            b_q       <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Stall covers the accepting cycle so the pipeline never advances past the op
    assign stall_o = (state_q != MDS_IDLE) || (start_i && md_is_muldiv(op_i) && !cancel_i);
    assign done_o  = (state_q == MDS_FIN) && !cancel_i;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule : muldiv_hilo_ctrl
`default_nettype wire

// File: tb/tb_muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_hilo_ctrl
//  Description : Self-checking bench for muldiv_hilo_ctrl: table of
//                directed mul/div vectors plus MTHI/MTLO, cancel and
//                mid-operation reset sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_muldiv_hilo_ctrl;
    import muldiv_hilo_ctrl_pkg::*;

    logic        clk;
    logic        resetn;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        cancel_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total;
    int bad;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[10];

    muldiv_hilo_ctrl #(
        .DATA_W   (32),
        .CNT_W    (6)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .cancel_i (cancel_i),
        .stall_o  (stall_o),
        .done_o   (done_o),
        .hi_o     (hi_o),
        .lo_o     (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Step to the drive point of the next cycle (1 time unit after the rising edge)
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issue one mul/div and check stall length, done position and HI/LO
    task automatic run_op(input int idx, input vec_t v);
        int stall_cnt;
        int done_cyc;
        int done_cnt;
        bit ended;
        stall_cnt = 0;
        done_cyc  = -1;
        done_cnt  = 0;
        ended     = 1'b0;
        next_cycle();
        start_i = 1'b1;
        op_i    = v.op;
        a_i     = v.a;
        b_i     = v.b;
        for (int c = 0; c < 60; c++) begin
            #3;
            if (stall_o) stall_cnt++;
            if (done_o) begin
                done_cyc = c;
                done_cnt++;
            end
            if (!stall_o) begin
                ended = 1'b1;
                break;
            end
            next_cycle();
            start_i = 1'b0;
            op_i    = MD_NONE;
        end
        if (!ended) begin
            total++;
            bad++;
            $display("FAIL v%0d timeout: stall_o still high after 60 cycles", idx);
        end
        chk($sformatf("v%0d stall_cycles", idx), 32'(stall_cnt), 32'd35);
        chk($sformatf("v%0d done_cycle", idx), 32'(done_cyc), 32'd34);
        chk($sformatf("v%0d done_pulses", idx), 32'(done_cnt), 32'd1);
        chk($sformatf("v%0d hi", idx), hi_o, v.exp_hi);
        chk($sformatf("v%0d lo", idx), lo_o, v.exp_lo);
    endtask

    initial begin
        int done_seen;
        total    = 0;
        bad      = 0;
        resetn   = 1'b0;
        start_i  = 1'b0;
        op_i     = MD_NONE;
        a_i      = '0;
        b_i      = '0;
        cancel_i = 1'b0;

        vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[2] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
        vecs[3] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[5] = '{MD_DIV,   32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF};
        vecs[6] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[7] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[8] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
        vecs[9] = '{MD_MULTU, 32'h0001_0000, 32'h0001_0003, 32'h0000_0001, 32'h0003_0000};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset hi", hi_o, 32'h0);
        chk("reset lo", lo_o, 32'h0);
        chk("reset stall", 32'(stall_o), 32'h0);
        chk("reset done", 32'(done_o), 32'h0);
        resetn = 1'b1;

        // Table-driven mul/div vectors
        for (int i = 0; i < 10; i++) begin
            run_op(i, vecs[i]);
        end

        // MTHI then MTLO back to back: no stall, each visible the following cycle
        next_cycle();
        start_i = 1'b1;
        op_i    = MD_MTHI;
        a_i     = 32'hDEAD_BEEF;
        #3;
        chk("mthi stall", 32'(stall_o), 32'h0);
        next_cycle();
        op_i    = MD_MTLO;
        a_i     = 32'h0BAD_F00D;
        #3;
        chk("mthi hi", hi_o, 32'hDEAD_BEEF);
        chk("mtlo stall", 32'(stall_o), 32'h0);
        next_cycle();
        start_i = 1'b0;
        op_i    = MD_NONE;
        #3;
        chk("mtlo lo", lo_o, 32'h0BAD_F00D);

        // MULT cancelled at T10; an MTHI presented while busy must be ignored
        done_seen = 0;
        next_cycle();
        start_i = 1'b1;
        op_i    = MD_MULT;
        a_i     = 32'h0000_0003;
        b_i     = 32'h0000_0004;
        for (int c = 0; c < 11; c++) begin
            #3;
            if (done_o) done_seen++;
            next_cycle();
            start_i  = (c + 1 == 5);
            op_i     = (c + 1 == 5) ? MD_MTHI : MD_NONE;
            a_i      = 32'h5555_5555;
            cancel_i = (c + 1 == 10);
        end
        #3;
        chk("cancel stall_T11", 32'(stall_o), 32'h0);
        chk("cancel no_done", 32'(done_seen), 32'h0);
        chk("cancel hi", hi_o, 32'hDEAD_BEEF);
        chk("cancel lo", lo_o, 32'h0BAD_F00D);

        // Cancel together with start in IDLE: nothing accepted
        next_cycle();
        start_i  = 1'b1;
        op_i     = MD_MTHI;
        a_i      = 32'h1111_1111;
        cancel_i = 1'b1;
        next_cycle();
        op_i     = MD_DIVU;
        #3;
        chk("cancel_idle mthi hi", hi_o, 32'hDEAD_BEEF);
        chk("cancel_idle div stall", 32'(stall_o), 32'h0);
        next_cycle();
        start_i  = 1'b0;
        op_i     = MD_NONE;
        cancel_i = 1'b0;
        #3;
        chk("cancel_idle not_busy", 32'(stall_o), 32'h0);

        // Reset asserted at T20 of a MULT
        next_cycle();
        start_i = 1'b1;
        op_i    = MD_MULT;
        a_i     = 32'h0000_0007;
        b_i     = 32'h0000_0009;
        for (int c = 0; c < 20; c++) begin
            next_cycle();
            start_i = 1'b0;
            op_i    = MD_NONE;
        end
        #3;
        chk("pre_reset busy", 32'(stall_o), 32'h1);
        resetn = 1'b0;
        #1;
        chk("midreset hi", hi_o, 32'h0);
        chk("midreset lo", lo_o, 32'h0);
        chk("midreset stall", 32'(stall_o), 32'h0);
        next_cycle();
        resetn = 1'b1;
        repeat (40) begin
            #3;
            if (stall_o || done_o) begin
                total++;
                bad++;
                $display("FAIL postreset idle: stall_o=%0b done_o=%0b expected 0", stall_o, done_o);
            end
            next_cycle();
        end
        chk("postreset hi", hi_o, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_muldiv_hilo_ctrl
`default_nettype wire
